// File: rtl/wb_regfile_if.sv
// Writeback-stage register file bus: MEM/WB buffer inputs, the two
// decode-stage read ports, and the registered PC-write / retire outputs.
//
// Handshake semantics: there is no ready side anywhere on this bus. The
// MEM/WB fields are sampled on every rising edge. pc_wr_valid is a
// one-cycle pulse the consumer must take in the cycle it is high.
// pc_wr_data holds its last value while pc_wr_valid is low.
interface wb_regfile_if #(
    parameter int DATA_W = 32
);
    logic [2:0]        wb_ctrl;      // [0] reg_write, [1] mem_to_reg, [2] byte_load
    logic [DATA_W-1:0] alu_data;
    logic [DATA_W-1:0] mem_data;
    logic [31:0]       instruction;  // all-zero word is a bubble
    logic [3:0]        rd1_addr;
    logic [3:0]        rd2_addr;
    logic [DATA_W-1:0] rd1_data;
    logic [DATA_W-1:0] rd2_data;
    logic              pc_wr_valid;
    logic [DATA_W-1:0] pc_wr_data;
    logic [31:0]       retire_count;

    // Pipeline side: drives writeback and read addresses, consumes results.
    modport master (
        output wb_ctrl, alu_data, mem_data, instruction, rd1_addr, rd2_addr,
        input  rd1_data, rd2_data, pc_wr_valid, pc_wr_data, retire_count
    );

    // Register file side.
    modport slave (
        input  wb_ctrl, alu_data, mem_data, instruction, rd1_addr, rd2_addr,
        output rd1_data, rd2_data, pc_wr_valid, pc_wr_data, retire_count
    );
endinterface

// File: rtl/wb_regfile.sv
// Writeback-stage register file: 15 general registers (r0..r14), r15 is the
// PC and lives elsewhere, so writes to r15 are forwarded as a registered
// one-cycle pulse instead. Two combinational read ports with same-cycle
// bypass of the writeback value, plus a retired-instruction counter.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int REG_N  = 16
) (
    input logic          clk,
    input logic          rst,
    wb_regfile_if.slave  bus
);
    // r15 is not stored; the array holds only r0..r14.
    localparam int         ARR_N  = REG_N - 1;
    localparam logic [3:0] PC_IDX = 4'd15;

    logic              reg_write;
    logic              mem_to_reg;
    logic              byte_load;
    logic [3:0]        dest;
    logic [DATA_W-1:0] wb_value;
    logic              arr_we;
    logic              pc_we;
    logic              retire_en;

    logic [DATA_W-1:0] regs [ARR_N];
    logic              pc_valid_q;
    logic [DATA_W-1:0] pc_data_q;
    logic [31:0]       retire_q;
    logic [DATA_W-1:0] rd1_value;
    logic [DATA_W-1:0] rd2_value;

    // Decode the writeback control word and destination.
    always_comb begin
        reg_write  = bus.wb_ctrl[0];
        mem_to_reg = bus.wb_ctrl[1];
        byte_load  = bus.wb_ctrl[2];
        dest       = bus.instruction[15:12];
    end

    // Select the writeback value; byte_load only matters for memory results.
    always_comb begin
        wb_value = bus.alu_data;
        if (mem_to_reg) begin
            if (byte_load) begin
                wb_value = {{(DATA_W-8){1'b0}}, bus.mem_data[7:0]};
            end else begin
                wb_value = bus.mem_data;
            end
        end
    end

    // Route a write either to the array or to the PC-write pulse.
    always_comb begin
        arr_we    = reg_write && (dest != PC_IDX);
        pc_we     = reg_write && (dest == PC_IDX);
        retire_en = (bus.instruction != 32'd0);
    end

    // Register array update; reset wins over a simultaneous write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ARR_N; i++) begin
                regs[i] <= '0;
            end
        end else if (arr_we) begin
            regs[dest] <= wb_value;
        end
    end

    // PC-write pulse: valid is high only in the cycle after an r15 write,
    // data holds the last forwarded value otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_valid_q <= 1'b0;
            pc_data_q  <= '0;
        end else begin
            pc_valid_q <= pc_we;
            if (pc_we) begin
                pc_data_q <= wb_value;
            end
        end
    end

    // Retire counter: every non-bubble instruction counts, wrapping naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_q <= 32'd0;
        end else if (retire_en) begin
            retire_q <= retire_q + 32'd1;
        end
    end

    // Read port 1: r15 reads zero, same-cycle array write is bypassed.
    always_comb begin
        rd1_value = '0;
        if (bus.rd1_addr != PC_IDX) begin
            if (arr_we && (dest == bus.rd1_addr)) begin
                rd1_value = wb_value;
            end else begin
                rd1_value = regs[bus.rd1_addr];
            end
        end
    end

    // Read port 2: identical behaviour, fully independent of port 1.
    always_comb begin
        rd2_value = '0;
        if (bus.rd2_addr != PC_IDX) begin
            if (arr_we && (dest == bus.rd2_addr)) begin
                rd2_value = wb_value;
            end else begin
                rd2_value = regs[bus.rd2_addr];
            end
        end
    end

    assign bus.rd1_data     = rd1_value;
    assign bus.rd2_data     = rd2_value;
    assign bus.pc_wr_valid  = pc_valid_q;
    assign bus.pc_wr_data   = pc_data_q;
    assign bus.retire_count = retire_q;
endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: a table of one-cycle vectors with hand-computed
// read-port and registered-output expectations, a small queue of expected
// PC-write values, and a hand-written counter wrap sequence.
module tb_wb_regfile;
  logic clk;
  logic rst;

  wb_regfile_if #(.DATA_W(32)) bus ();

  wb_regfile #(.DATA_W(32), .REG_N(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic [2:0]  ctrl;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [31:0] instr;
    logic [3:0]  a1;
    logic [3:0]  a2;
    logic        chk_rd;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        e_pcv;
    logic [31:0] e_pcd;
    logic [31:0] e_ret;
  } vec_t;

  vec_t vq[$];
  logic [31:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] mk(input logic [3:0] d);
    return {16'hE3A0, d, 12'h000};
  endfunction

  function automatic logic [31:0] wb_val(input logic [2:0] c, input logic [31:0] alu,
                                         input logic [31:0] mem);
    if (!c[1]) return alu;
    if (c[2]) return {24'h0, mem[7:0]};
    return mem;
  endfunction

  task automatic add(input logic r, input logic [2:0] c, input logic [31:0] alu,
                     input logic [31:0] mem, input logic [31:0] ins,
                     input logic [3:0] a1, input logic [3:0] a2, input logic ck,
                     input logic [31:0] e1, input logic [31:0] e2,
                     input logic pv, input logic [31:0] pd, input logic [31:0] rt);
    vec_t v;
    v.rst = r; v.ctrl = c; v.alu = alu; v.mem = mem; v.instr = ins;
    v.a1 = a1; v.a2 = a2; v.chk_rd = ck; v.e1 = e1; v.e2 = e2;
    v.e_pcv = pv; v.e_pcd = pd; v.e_ret = rt;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input vec_t v);
    rst             = v.rst;
    bus.wb_ctrl     = v.ctrl;
    bus.alu_data    = v.alu;
    bus.mem_data    = v.mem;
    bus.instruction = v.instr;
    bus.rd1_addr    = v.a1;
    bus.rd2_addr    = v.a2;
  endtask

  // ---------------- main test ----------------
  initial begin
    rst = 1'b1;
    bus.wb_ctrl = 3'b000; bus.alu_data = '0; bus.mem_data = '0;
    bus.instruction = '0; bus.rd1_addr = '0; bus.rd2_addr = '0;

    //   rst ctrl    alu           mem           instr     a1 a2 chk e1            e2            pcv pcd           ret
    add(1, 3'b000, 32'h0,        32'h0,        32'h0,    0, 1, 0, 32'h0,        32'h0,        0, 32'h0,        0);
    add(1, 3'b001, 32'h12345678, 32'h0,        mk(3),    3, 3, 1, 32'h12345678, 32'h12345678, 0, 32'h0,        0);
    add(0, 3'b000, 32'h0,        32'h0,        32'h0,    3, 4, 1, 32'h0,        32'h0,        0, 32'h0,        0);
    add(0, 3'b001, 32'h12345678, 32'h0,        mk(3),    3, 2, 1, 32'h12345678, 32'h0,        0, 32'h0,        1);
    add(0, 3'b000, 32'h0,        32'h0,        32'h0,    3, 15, 1, 32'h12345678, 32'h0,       0, 32'h0,        1);
    add(0, 3'b111, 32'h11112222, 32'hDEADBEEF, mk(5),    5, 3, 1, 32'h000000EF, 32'h12345678, 0, 32'h0,        2);
    add(0, 3'b011, 32'h11112222, 32'hDEADBEEF, mk(5),    5, 5, 1, 32'hDEADBEEF, 32'hDEADBEEF, 0, 32'h0,        3);
    add(0, 3'b101, 32'h11112222, 32'hDEADBEEF, mk(5),    5, 6, 1, 32'h11112222, 32'h0,        0, 32'h0,        4);
    add(0, 3'b000, 32'h99999999, 32'h0,        mk(5),    5, 3, 1, 32'h11112222, 32'h12345678, 0, 32'h0,        5);
    add(0, 3'b001, 32'h00000100, 32'h0,        mk(15),   15, 15, 1, 32'h0,      32'h0,        1, 32'h100,      6);
    add(0, 3'b000, 32'h0,        32'h0,        32'h0,    15, 5, 1, 32'h0,       32'h11112222, 0, 32'h100,      6);
    add(0, 3'b111, 32'h55555555, 32'h000012AB, mk(15),   15, 5, 1, 32'h0,       32'h11112222, 1, 32'h000000AB, 7);
    add(0, 3'b001, 32'h00000200, 32'h0,        mk(15),   5, 15, 1, 32'h11112222, 32'h0,       1, 32'h200,      8);
    add(0, 3'b000, 32'h77777777, 32'h0,        mk(0),    0, 15, 1, 32'h0,       32'h0,        0, 32'h200,      9);
    add(0, 3'b001, 32'h00000001, 32'h0,        mk(1),    1, 1, 1, 32'h1,        32'h1,        0, 32'h200,      10);
    add(0, 3'b001, 32'h00000002, 32'h0,        mk(1),    1, 1, 1, 32'h2,        32'h2,        0, 32'h200,      11);
    add(0, 3'b000, 32'h0,        32'h0,        32'h0,    1, 1, 1, 32'h2,        32'h2,        0, 32'h200,      11);
    add(0, 3'b001, 32'hCAFEF00D, 32'h0,        mk(0),    0, 1, 1, 32'hCAFEF00D, 32'h2,        0, 32'h200,      12);
    add(0, 3'b001, 32'h14141414, 32'h0,        mk(14),   14, 0, 1, 32'h14141414, 32'hCAFEF00D, 0, 32'h200,     13);
    add(0, 3'b001, 32'hA5A5A5A5, 32'h0,        mk(7),    7, 14, 1, 32'hA5A5A5A5, 32'h14141414, 0, 32'h200,     14);
    add(1, 3'b001, 32'h00000001, 32'h0,        mk(7),    7, 14, 1, 32'h1,       32'h14141414, 0, 32'h0,        0);
    add(0, 3'b000, 32'h0,        32'h0,        32'h0,    7, 14, 1, 32'h0,       32'h0,        0, 32'h0,        0);
    add(0, 3'b001, 32'h00000300, 32'h0,        mk(15),   0, 15, 1, 32'h0,       32'h0,        1, 32'h300,      1);
    add(1, 3'b001, 32'h00000400, 32'h0,        mk(15),   0, 15, 1, 32'h0,       32'h0,        0, 32'h0,        0);
    add(0, 3'b000, 32'h0,        32'h0,        32'h0,    1, 5, 1, 32'h0,        32'h0,        0, 32'h0,        0);

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i]);
      if (!vq[i].rst && vq[i].ctrl[0] && (vq[i].instr[15:12] == 4'd15))
        exp_q.push_back(wb_val(vq[i].ctrl, vq[i].alu, vq[i].mem));
      #1;
      if (vq[i].chk_rd) begin
        check($sformatf("v%0d rd1", i), bus.rd1_data, vq[i].e1);
        check($sformatf("v%0d rd2", i), bus.rd2_data, vq[i].e2);
      end
      @(posedge clk);
      #1;
      check($sformatf("v%0d pc_wr_valid", i), {31'h0, bus.pc_wr_valid}, {31'h0, vq[i].e_pcv});
      check($sformatf("v%0d pc_wr_data", i), bus.pc_wr_data, vq[i].e_pcd);
      check($sformatf("v%0d retire_count", i), bus.retire_count, vq[i].e_ret);
      if (bus.pc_wr_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check($sformatf("v%0d unexpected pc write", i), bus.pc_wr_data, 32'hXXXXXXXX);
        end else begin
          check($sformatf("v%0d pc scoreboard", i), bus.pc_wr_data, exp_q.pop_front());
        end
      end
    end
    check("pc scoreboard leftover", exp_q.size(), 0);

    // Counter wrap: preset to FFFFFFFE, two retirements, then a bubble.
    @(negedge clk);
    rst = 1'b0;
    bus.wb_ctrl = 3'b000;
    bus.instruction = mk(2);
    force dut.retire_q = 32'hFFFFFFFE;
    #1;
    release dut.retire_q;
    @(posedge clk); #1;
    check("wrap step1", bus.retire_count, 32'hFFFFFFFF);
    @(posedge clk); #1;
    check("wrap step2", bus.retire_count, 32'h0);
    @(negedge clk);
    bus.instruction = 32'h0;
    @(posedge clk); #1;
    check("wrap bubble", bus.retire_count, 32'h0);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameters SHALL be: DATA_W, 32, data/register width; REG_N, 16, register count (fixed at 16; 4-bit addresses).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 wb_ctrl  input  3  writeback control from MEM/WB buffer: [0] reg_write, [1] mem_to_reg, [2] byte_load.
REQ-005 alu_data  input  32  ALU result from MEM/WB buffer.
REQ-006 mem_data  input  32  memory read data from MEM/WB buffer.
REQ-007 instruction  input  32  instruction word from MEM/WB buffer; all-zero word = bubble.
REQ-008 rd1_addr, rd2_addr  input  4 each  decode-stage read addresses.
REQ-009 rd1_data, rd2_data  output  32 each  combinational read data.
REQ-010 pc_wr_valid  output  1  registered one-cycle pulse: writeback targeted r15.
REQ-011 pc_wr_data  output  32  registered value for the r15 write.
REQ-012 retire_count  output  32  registered count of retired non-bubble instructions.

Function
REQ-013 Destination register SHALL be instruction[15:12].
REQ-014 Writeback value SHALL be alu_data when mem_to_reg=0; mem_data when mem_to_reg=1 and byte_load=0; {24'b0, mem_data[7:0]} when mem_to_reg=1 and byte_load=1.
REQ-015 byte_load SHALL be ignored when mem_to_reg=0.
REQ-016 When reg_write=1 and dest in 0..14, register[dest] SHALL take the writeback value at the next rising edge.
REQ-017 When reg_write=1 and dest=15, the register array SHALL NOT be written; pc_wr_valid SHALL be 1 and pc_wr_data SHALL equal the writeback value for exactly the following cycle.
REQ-018 pc_wr_valid SHALL be 0 in every cycle not caused by REQ-017; pc_wr_data SHALL hold its last value when pc_wr_valid=0.
REQ-019 When reg_write=0, no register and no PC output SHALL change.
REQ-020 rd1_data/rd2_data SHALL be register[addr] combinationally, except bypass: when reg_write=1, dest in 0..14 and addr equals dest in the same cycle, output SHALL be the current writeback value.
REQ-021 Reading address 15 SHALL return 32'b0 (PC not held here); no bypass for 15.
REQ-022 Both read ports SHALL be independent; same address on both ports returns identical data.
REQ-023 retire_count SHALL increment by 1 at each rising edge where instruction != 0, regardless of reg_write; it SHALL wrap 32'hFFFFFFFF -> 0.
REQ-024 Write latency 1 cycle; bypass latency 0 cycles; retire_count and pc_wr_* latency 1 cycle.

Reset
REQ-025 rst=1 at a rising edge SHALL clear all 15 registers, retire_count, pc_wr_valid and pc_wr_data to 0.
REQ-026 rst SHALL take priority over a simultaneous write, r15 write or retire increment; none takes effect.
REQ-027 Bypass in REQ-020 SHALL remain combinational while rst=1; array contents read 0 after the reset edge.
REQ-028 No initial-block values SHALL be relied upon; state is defined only after the first reset edge.

Verification
REQ-029 Reset, then wb_ctrl=3'b001, instruction[15:12]=3, alu_data=32'h12345678 -> same cycle rd1_addr=3 reads 12345678 (bypass); next cycle with reg_write=0 still 12345678; retire_count=1.
REQ-030 wb_ctrl=3'b111, dest=5, mem_data=32'hDEADBEEF -> r5=32'h000000EF; wb_ctrl=3'b011 same inputs -> r5=32'hDEADBEEF; wb_ctrl=3'b101 -> r5=alu_data.
REQ-031 wb_ctrl=3'b001, dest=15, alu_data=32'h00000100 -> next cycle pc_wr_valid=1, pc_wr_data=32'h100; following cycle pc_wr_valid=0; rd1_addr=15 reads 0 throughout.
REQ-032 Write r7=32'hA5A5A5A5, then rst=1 in same cycle as write r7=32'h1 with non-zero instruction -> after edge r7=0, retire_count=0, pc_wr_valid=0.
REQ-033 Preload retire_count to 32'hFFFFFFFE by 0xFFFFFFFE retirements (or force), two non-bubble instructions then one bubble -> counts FFFFFFFF, 0, 0.
REQ-034 Back-to-back writes r1=1, r1=2 with rd1_addr=rd2_addr=1 -> both ports read 1 then 2 in the write cycles (bypass), 2 afterwards.
